master_cmd_sequencer: RTL

//  Command front-end placed directly upstream of one bus `master` instance.

---
 rtl/master_cmd_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/master_cmd_sequencer.sv
// Command front-end for one bus master: queues read/write commands and runs them
// one at a time on the master's local port, returning data and a status per command.
module master_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDRS_WIDTH = 15,
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned TIMEOUT_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [ADDRS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_rw,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic [FIFO_AW:0]       fifo_count,
  output logic                   m_hold,
  output logic                   m_execute,
  output logic                   m_RW,
  output logic [ADDRS_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0]  m_din,
  input  logic [DATA_WIDTH-1:0]  m_dout,
  input  logic                   m_dvalid,
  input  logic                   m_master_bsy,
  output logic [2:0]             state
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned EntW  = 1 + ADDRS_WIDTH + DATA_WIDTH;
  localparam logic [FIFO_AW:0]       FullCount  = (FIFO_AW + 1)'(Depth);
  localparam logic [TIMEOUT_LEN-1:0] TimerLimit = '1;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrNoStart = 2'b01;
  localparam logic [1:0] ErrStuck   = 2'b10;
  localparam logic [1:0] ErrNoData  = 2'b11;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLaunch   = 3'd1,
    StWaitBsy  = 3'd2,
    StWaitDone = 3'd3,
    StResp     = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Command FIFO
  logic [EntW-1:0]    mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               push, pop;
  logic [EntW-1:0]    head;

  assign cmd_ready  = (count_q != FullCount);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == StResp);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  // Transaction sequencing
  logic [TIMEOUT_LEN-1:0] timer_q, timer_d;
  logic                   m_rw_q, m_rw_d;
  logic [ADDRS_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]  m_din_q, m_din_d;
  logic [DATA_WIDTH-1:0]  cap_q, cap_d;
  logic                   seen_q, seen_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             err_q, err_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    m_rw_d   = m_rw_q;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    cap_d    = cap_q;
    seen_d   = seen_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d  = StLaunch;
          m_rw_d   = head[EntW-1];
          m_addr_d = head[EntW-2 -: ADDRS_WIDTH];
          m_din_d  = head[DATA_WIDTH-1:0];
        end
      end
      StLaunch: begin
        state_d = StWaitBsy;
        timer_d = '0;
        seen_d  = 1'b0;
        cap_d   = '0;
      end
      StWaitBsy: begin
        if (m_master_bsy) begin
          state_d = StWaitDone;
          timer_d = '0;
        end else if (timer_q == TimerLimit) begin
          state_d = StResp;
          err_d   = ErrNoStart;
          rdata_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitDone: begin
        // Only the first dvalid pulse of a read is kept.
        if (m_dvalid && !m_rw_q && !seen_q) begin
          seen_d = 1'b1;
          cap_d  = m_dout;
        end
        if (!m_master_bsy) begin
          state_d = StResp;
          if (!m_rw_q && !seen_d) begin
            err_d   = ErrNoData;
            rdata_d = '0;
          end else begin
            err_d   = ErrOk;
            rdata_d = m_rw_q ? '0 : cap_d;
          end
        end else if (timer_q == TimerLimit) begin
          state_d = StResp;
          err_d   = ErrStuck;
          rdata_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      m_rw_q   <= 1'b0;
      m_addr_q <= '0;
      m_din_q  <= '0;
      cap_q    <= '0;
      seen_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      m_rw_q   <= m_rw_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      cap_q    <= cap_d;
      seen_q   <= seen_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign m_hold    = (state_q == StLaunch) || (state_q == StWaitBsy) || (state_q == StWaitDone);
  assign m_execute = (state_q == StLaunch);
  assign m_RW      = m_rw_q;
  assign m_address = m_addr_q;
  assign m_din     = m_din_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rw    = m_rw_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign state     = state_q;

endmodule
